// File: rtl/axis_cfg_arbiter.sv
// Round-robin arbiter that turns write/read transfer descriptors into fixed
// three-beat configuration sequences (engine select, base address, length)
// on the shared, non-back-pressured configuration port of the axis DMA block.
module axis_cfg_arbiter #(
  parameter int unsigned CFG_ID_WR  = 1,
  parameter int unsigned CFG_ID_RD  = 2,
  parameter int unsigned CFG_ADDR   = 23,
  parameter int unsigned CFG_DATA   = 24,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_GAP    = 2,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_valid,
  input  logic [CFG_DWIDTH-1:0] wr_req_addr,
  input  logic [CFG_DWIDTH-1:0] wr_req_len,
  output logic                  wr_req_ready,
  input  logic                  rd_req_valid,
  input  logic [CFG_DWIDTH-1:0] rd_req_addr,
  input  logic [CFG_DWIDTH-1:0] rd_req_len,
  output logic                  rd_req_ready,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam logic [CFG_AWIDTH-1:0] IdWr    = CFG_AWIDTH'(CFG_ID_WR);
  localparam logic [CFG_AWIDTH-1:0] IdRd    = CFG_AWIDTH'(CFG_ID_RD);
  localparam logic [CFG_AWIDTH-1:0] RegAddr = CFG_AWIDTH'(CFG_ADDR);
  localparam logic [CFG_AWIDTH-1:0] RegLen  = CFG_AWIDTH'(CFG_DATA);
  localparam logic [3:0]            GapInit = 4'(CFG_GAP);

  typedef enum logic [2:0] {StIdle, StSel, StAddr, StLen, StGap} state_e;

  state_e                  state_q, state_d;
  // Last granted requester; 1 = write. Also serves as the captured engine id.
  logic                    last_wr_q, last_wr_d;
  logic [CFG_DWIDTH-1:0]   addr_q, addr_d;
  logic [CFG_DWIDTH-1:0]   len_q, len_d;
  logic [3:0]              gap_q, gap_d;
  logic [DROP_WIDTH-1:0]   drop_q, drop_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic [CFG_AWIDTH-1:0]   cfg_addr_q, cfg_addr_d;
  logic [CFG_DWIDTH-1:0]   cfg_data_q, cfg_data_d;

  logic                    idle, grant_wr, grant_rd, hs_wr, hs_rd;
  logic [CFG_DWIDTH-1:0]   hs_len;

  // Round-robin grant: a lone requester wins, otherwise the one not served last.
  always_comb begin
    idle     = (state_q == StIdle);
    grant_wr = wr_req_valid & (~rd_req_valid | ~last_wr_q);
    grant_rd = rd_req_valid & (~wr_req_valid | last_wr_q);
    hs_wr    = wr_req_valid & idle & grant_wr;
    hs_rd    = rd_req_valid & idle & grant_rd;
    hs_len   = hs_wr ? wr_req_len : rd_req_len;
  end

  assign wr_req_ready = idle & grant_wr;
  assign rd_req_ready = idle & grant_rd;

  // Next state; the cfg outputs are precomputed here so that each beat appears
  // in the same cycle as the state that names it.
  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    gap_d       = gap_q;
    drop_d      = drop_q;
    cfg_valid_d = 1'b0;
    cfg_addr_d  = '0;
    cfg_data_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (hs_wr || hs_rd) begin
          last_wr_d = hs_wr;
          addr_d    = hs_wr ? wr_req_addr : rd_req_addr;
          len_d     = hs_len;
          if (hs_len != '0) begin
            state_d     = StSel;
            cfg_valid_d = 1'b1;
            cfg_addr_d  = hs_wr ? IdWr : IdRd;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
      end
      StSel: begin
        state_d     = StAddr;
        cfg_valid_d = 1'b1;
        cfg_addr_d  = RegAddr;
        cfg_data_d  = addr_q;
      end
      StAddr: begin
        state_d     = StLen;
        cfg_valid_d = 1'b1;
        cfg_addr_d  = RegLen;
        cfg_data_d  = len_q;
      end
      StLen: begin
        if (GapInit == 4'd0) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          gap_d   = GapInit;
        end
      end
      StGap: begin
        if (gap_q <= 4'd1) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_wr_q   <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      drop_q      <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      drop_q      <= drop_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  assign cfg_valid  = cfg_valid_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_data   = cfg_data_q;
  assign busy       = (state_q != StIdle);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_axis_cfg_arbiter.sv
// Directed bench for axis_cfg_arbiter: instance a uses the default parameters,
// instance b uses CFG_GAP=0 and DROP_WIDTH=2.
module tb_axis_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic        wr_req_valid, rd_req_valid, wr_req_ready, rd_req_ready;
  logic [31:0] wr_req_addr, wr_req_len, rd_req_addr, rd_req_len;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid, busy;
  logic [7:0]  drop_count;

  logic        b_wr_req_valid, b_rd_req_valid, b_wr_req_ready, b_rd_req_ready;
  logic [31:0] b_wr_req_addr, b_wr_req_len, b_rd_req_addr, b_rd_req_len;
  logic [4:0]  b_cfg_addr;
  logic [31:0] b_cfg_data;
  logic        b_cfg_valid, b_busy;
  logic [1:0]  b_drop_count;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_cfg_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_len   (wr_req_len),
    .wr_req_ready (wr_req_ready),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_req_ready (rd_req_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  axis_cfg_arbiter #(
    .CFG_GAP    (0),
    .DROP_WIDTH (2)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .wr_req_valid (b_wr_req_valid),
    .wr_req_addr  (b_wr_req_addr),
    .wr_req_len   (b_wr_req_len),
    .wr_req_ready (b_wr_req_ready),
    .rd_req_valid (b_rd_req_valid),
    .rd_req_addr  (b_rd_req_addr),
    .rd_req_len   (b_rd_req_len),
    .rd_req_ready (b_rd_req_ready),
    .cfg_addr     (b_cfg_addr),
    .cfg_data     (b_cfg_data),
    .cfg_valid    (b_cfg_valid),
    .busy         (b_busy),
    .drop_count   (b_drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic v, input logic [31:0] a,
                      input logic [31:0] d);
    check({tag, "_valid"}, {31'd0, cfg_valid}, {31'd0, v});
    check({tag, "_addr"}, {27'd0, cfg_addr}, a);
    check({tag, "_data"}, cfg_data, d);
  endtask

  task automatic do_reset();
    wr_req_valid   = 1'b0;
    rd_req_valid   = 1'b0;
    b_wr_req_valid = 1'b0;
    b_rd_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Returns while a handshake on instance a is pending at the next edge.
  task automatic wait_hs(output logic is_wr, output int unsigned t);
    is_wr = 1'b0;
    t     = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (wr_req_valid && wr_req_ready) begin
        is_wr = 1'b1;
        t     = cyc;
        return;
      end
      if (rd_req_valid && rd_req_ready) begin
        t = cyc;
        return;
      end
      tick();
    end
    check("hs_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic        w;
    logic        found;
    int unsigned t, tprev, nv, nh, last;
    logic        rd_seen;

    wr_req_addr = '0; wr_req_len = '0; rd_req_addr = '0; rd_req_len = '0;
    b_wr_req_addr = '0; b_wr_req_len = '0; b_rd_req_addr = '0; b_rd_req_len = '0;
    tprev = 0;

    // Reset values
    do_reset();
    beat("rst", 1'b0, 32'd0, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_req_ready}, 32'd0);

    // Single write descriptor
    wr_req_valid = 1'b1; wr_req_addr = 32'h1000_0000; wr_req_len = 32'h100;
    #1;
    check("single_wr_ready", {31'd0, wr_req_ready}, 32'd1);
    rd_seen = rd_req_ready;
    wait_hs(w, t);
    check("single_grant", {31'd0, w}, 32'd1);
    tick();
    wr_req_valid = 1'b0;
    beat("single_sel", 1'b1, 32'd1, 32'd0);
    check("single_busy1", {31'd0, busy}, 32'd1);
    rd_seen |= rd_req_ready;
    tick();
    beat("single_addr", 1'b1, 32'd23, 32'h1000_0000);
    rd_seen |= rd_req_ready;
    tick();
    beat("single_len", 1'b1, 32'd24, 32'h100);
    rd_seen |= rd_req_ready;
    tick();
    beat("single_gap1", 1'b0, 32'd0, 32'd0);
    check("single_busy4", {31'd0, busy}, 32'd1);
    rd_seen |= rd_req_ready;
    tick();
    check("single_busy5", {31'd0, busy}, 32'd1);
    rd_seen |= rd_req_ready;
    tick();
    check("single_busy6", {31'd0, busy}, 32'd0);
    rd_seen |= rd_req_ready;
    check("single_rd_ready", {31'd0, rd_seen}, 32'd0);

    // Contention: grants alternate WR, RD, WR, RD, 6 cycles apart
    do_reset();
    wr_req_valid = 1'b1; wr_req_addr = 32'hA0; wr_req_len = 32'd5;
    rd_req_valid = 1'b1; rd_req_addr = 32'hB0; rd_req_len = 32'd7;
    for (int k = 0; k < 4; k++) begin
      wait_hs(w, t);
      check("cont_grant", {31'd0, w}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0) check("cont_period", t - tprev, 32'd6);
      tprev = t;
      tick();
      beat("cont_sel", 1'b1, (k % 2 == 0) ? 32'd1 : 32'd2, 32'd0);
      tick();
      beat("cont_addr", 1'b1, 32'd23, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      tick();
      beat("cont_len", 1'b1, 32'd24, (k % 2 == 0) ? 32'd5 : 32'd7);
    end
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;

    // Zero-length write dropped, read follows one cycle later
    do_reset();
    wr_req_valid = 1'b1; wr_req_addr = 32'hDEAD; wr_req_len = 32'd0;
    rd_req_valid = 1'b1; rd_req_addr = 32'h55; rd_req_len = 32'd8;
    wait_hs(w, tprev);
    check("zl_grant_wr", {31'd0, w}, 32'd1);
    tick();
    wr_req_valid = 1'b0;
    check("zl_no_beat", {31'd0, cfg_valid}, 32'd0);
    check("zl_drop", {24'd0, drop_count}, 32'd1);
    check("zl_busy", {31'd0, busy}, 32'd0);
    wait_hs(w, t);
    check("zl_grant_rd", {31'd0, w}, 32'd0);
    check("zl_rd_delay", t - tprev, 32'd1);
    tick();
    rd_req_valid = 1'b0;
    beat("zl_sel", 1'b1, 32'd2, 32'd0);
    tick();
    beat("zl_addr", 1'b1, 32'd23, 32'h55);
    tick();
    beat("zl_len", 1'b1, 32'd24, 32'd8);

    // Drop counter saturation (instance b, 2-bit counter)
    do_reset();
    b_wr_req_valid = 1'b1; b_wr_req_addr = 32'h1; b_wr_req_len = 32'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sat_drop", {30'd0, b_drop_count}, (k < 3) ? 32'(k + 1) : 32'd3);
    end
    b_wr_req_valid = 1'b0;
    check("sat_no_beat", {31'd0, b_cfg_valid}, 32'd0);

    // Reset asserted during the ADDR beat
    do_reset();
    wr_req_valid = 1'b1; wr_req_addr = 32'h1234; wr_req_len = 32'd9;
    wait_hs(w, t);
    tick();
    wr_req_valid = 1'b0;
    tick();
    beat("mid_addr", 1'b1, 32'd23, 32'h1234);
    #1;
    rst = 1'b1;
    #1;
    beat("mid_rst_now", 1'b0, 32'd0, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    check("mid_rst_hold", {31'd0, cfg_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_no_len", {31'd0, cfg_valid}, 32'd0);
    wr_req_valid = 1'b1; wr_req_addr = 32'h2222; wr_req_len = 32'd3;
    wait_hs(w, t);
    tick();
    wr_req_valid = 1'b0;
    beat("mid_new_sel", 1'b1, 32'd1, 32'd0);
    tick();
    beat("mid_new_addr", 1'b1, 32'd23, 32'h2222);
    tick();
    beat("mid_new_len", 1'b1, 32'd24, 32'd3);

    // CFG_GAP=0 (instance b): handshake every 4 cycles, 3 of 4 beats valid
    do_reset();
    b_rd_req_valid = 1'b1; b_rd_req_addr = 32'h77; b_rd_req_len = 32'd4;
    #1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (b_rd_req_ready) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("gap0_first_hs", {31'd0, found}, 32'd1);
    nv = 0; nh = 0; last = 0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j == 1) check("gap0_sel_id", {27'd0, b_cfg_addr}, 32'd2);
      if (b_cfg_valid) nv++;
      if (b_rd_req_valid && b_rd_req_ready) begin
        if (j % 4 != 0) check("gap0_hs_phase", j, 32'(4 * ((j + 3) / 4)));
        nh++;
        last = j;
      end
    end
    b_rd_req_valid = 1'b0;
    check("gap0_valid_cycles", nv, 32'd12);
    check("gap0_handshakes", nh, 32'd4);
    check("gap0_last_hs", last, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_cfg_arbiter.md
# axis_cfg_arbiter

Arbitrating sequencer that drives the shared configuration port (`cfg_addr`/`cfg_data`/`cfg_valid`) of the `axis` DMA block. It accepts transfer descriptors (base address, length) from two independent requesters: one for the write path and one for the read path. It grants them round-robin and serialises each descriptor into a fixed three-beat configuration sequence addressed to the selected engine. The configuration port has no back-pressure, so this block owns all pacing of configuration traffic.

## Interface
- `CFG_ID_WR`, 1: engine-select register address for the write engine.
- `CFG_ID_RD`, 2: engine-select register address for the read engine.
- `CFG_ADDR`, 23: base-address register address.
- `CFG_DATA`, 24: transfer-length register address.
- `CFG_AWIDTH`, 5: width of `cfg_addr`.
- `CFG_DWIDTH`, 32: width of `cfg_data`, descriptor address and descriptor length.
- `CFG_GAP`, 2: idle cycles forced after each sequence (0–15).
- `DROP_WIDTH`, 8: width of the zero-length drop counter.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_req_valid` in 1: write descriptor valid.
- `wr_req_addr` in CFG_DWIDTH: write base address.
- `wr_req_len` in CFG_DWIDTH: write length, in stream words.
- `wr_req_ready` out 1: write descriptor accepted this cycle.
- `rd_req_valid`, `rd_req_addr`, `rd_req_len`, `rd_req_ready`: same as the write signals, for the read engine.
- `cfg_addr` out CFG_AWIDTH: configuration register address (registered).
- `cfg_data` out CFG_DWIDTH: configuration data (registered).
- `cfg_valid` out 1: configuration beat valid (registered).
- `busy` out 1: high in any state other than IDLE.
- `drop_count` out DROP_WIDTH: count of zero-length descriptors discarded; saturates at all-ones.

## Operation
- FSM states are IDLE, SEL, ADDR, LEN and GAP.
- **IDLE.** Arbiter grants one requester.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last time wins.
  - `last_grant` resets to RD, so write wins the first contended grant.
- **Ready signals.** `x_req_ready = (state==IDLE) & grant_x`; this is combinational.
  - A handshake is `valid & ready`.
  - At most one ready is high per cycle.
- **On handshake.** The block captures addr, len and the engine id, and updates `last_grant`.
  - If len ≠ 0: go to SEL.
  - If len == 0: discard the descriptor, increment `drop_count` (saturating), and stay in IDLE. No beats are issued; `last_grant` still updates.
- **SEL.** Drive `cfg_valid`=1, `cfg_addr`=CFG_ID_WR or CFG_ID_RD, `cfg_data`=0. Go to ADDR.
- **ADDR.** Drive `cfg_valid`=1, `cfg_addr`=CFG_ADDR, `cfg_data`=captured address. Go to LEN.
- **LEN.** Drive `cfg_valid`=1, `cfg_addr`=CFG_DATA, `cfg_data`=captured length.
  - Go to GAP with the gap counter loaded to CFG_GAP.
  - If CFG_GAP==0, go to IDLE instead.
- **GAP.** Count down; `cfg_valid`=0. On reaching 1, go to IDLE.
- **Outputs outside beats.** Whenever `cfg_valid`=0, `cfg_addr` and `cfg_data` are driven to 0.
- **Address width.** `cfg_addr` values are truncated to CFG_AWIDTH bits. Parameter values that do not fit are illegal.
- **Descriptor changes.** A requester that drops valid before being granted is not an error. Descriptor inputs are sampled only at the handshake edge.

## Timing
- **Reset values.** `cfg_valid`=0, `cfg_addr`=0, `cfg_data`=0, `busy`=0, `drop_count`=0, state=IDLE, `last_grant`=RD, both readies 0 until the state is IDLE.
- **Reset assertion.** Asserting `rst` mid-sequence clears `cfg_valid` immediately (asynchronously). The remaining beats are abandoned and not replayed.
- **Latency.** For a handshake at edge N, the SEL, ADDR and LEN beats are valid in cycles N+1, N+2 and N+3 (one beat per cycle, no gaps inside a sequence).
- **Throughput.**
  - GAP occupies cycles N+4 through N+3+CFG_GAP.
  - IDLE is re-entered at cycle N+4+CFG_GAP, which is the earliest next handshake.
  - The minimum descriptor period is 4+CFG_GAP cycles.
- **Back-to-back zero-length descriptors.** Accepted at one per cycle; `drop_count` increments each cycle.
- **Simultaneous valid requests.** Grants strictly alternate WR, RD, WR, and so on.

## Test plan
- **Single write descriptor.** Reset, then addr=0x1000_0000, len=0x100, CFG_GAP=2.
  - Required: beats (1,0), (23,0x1000_0000), (24,0x100) on cycles N+1..N+3.
  - Required: `busy` high N+1..N+5; `rd_req_ready` never high.
- **Contention.** Both requesters continuously valid with distinct descriptors.
  - Required: the first sequence uses id 1, then 2, 1, 2.
  - Required: handshakes exactly 6 cycles apart.
- **Zero-length descriptor.** `wr` len=0, then `rd` len=8.
  - Required: no beat for the write descriptor; `drop_count`=1.
  - Required: the read sequence starts one cycle after the write handshake.
- **Drop counter saturation.** DROP_WIDTH=2; five zero-length descriptors.
  - Required: `drop_count` reads 1, 2, 3, 3, 3.
- **Reset mid-sequence.** Assert `rst` during the ADDR beat.
  - Required: `cfg_valid` is 0 in the same cycle and stays 0 with no LEN beat.
  - Required: after release, a new write descriptor produces a full three-beat sequence.
- **CFG_GAP=0.** Continuous read requests.
  - Required: handshake every 4 cycles; `cfg_valid` high 3 of every 4 cycles.
